// File: rtl/sobel_window3x3.sv
// sobel_window3x3: RGB -> luma, two-line buffering and a registered 3x3 window for the Sobel stage.
// Optional feature macro: SOBEL_WIN_LUMA_EN (defined: luma=(R+2G+B)>>2, undefined: luma=G).
`default_nettype none

module sobel_window3x3 #(
  parameter int H_ACTIVE = 640,
  parameter int COL_W    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic        sof,
  input  logic        sol,
  input  logic [23:0] rgb_in,
  output logic        win_valid,
  output logic [71:0] win,
  output logic [7:0]  gray_out
);

  localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  logic [7:0] luma;
`ifdef SOBEL_WIN_LUMA_EN
  logic [9:0] luma_sum;
  logic       unused_luma;
  assign luma_sum    = {2'b00, rgb_in[23:16]} + {1'b0, rgb_in[15:8], 1'b0} + {2'b00, rgb_in[7:0]};
  assign luma        = luma_sum[9:2];
  assign unused_luma = ^luma_sum[1:0];
`else
  logic unused_rgb;
  assign luma       = rgb_in[15:8];
  assign unused_rgb = ^{rgb_in[23:16], rgb_in[7:0]};
`endif

  // Position counters remember the last accepted pixel; dropped pixels leave them untouched.
  logic [COL_W-1:0] col_cnt_q, col_cnt_d, pix_col;
  logic [1:0]       row_cnt_q, row_cnt_d, pix_row;
  logic             pix_acc;

  logic [7:0]       gray_q, gray_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic             acc_q, acc_d;

  logic [71:0]      win_q, win_d;
  logic             win_valid_q, win_valid_d;

  logic [7:0]       lb0 [H_ACTIVE];
  logic [7:0]       lb1 [H_ACTIVE];
  logic [AW-1:0]    lb_addr;
  logic [7:0]       lb0_rd, lb1_rd;

  assign lb_addr = col_q[AW-1:0];
  assign lb0_rd  = lb0[lb_addr];
  assign lb1_rd  = lb1[lb_addr];

  always_comb begin
    pix_col = col_cnt_q + COL_W'(1);
    pix_row = row_cnt_q;
    if (sof) begin
      pix_col = '0;
      pix_row = 2'd0;
    end else if (sol) begin
      pix_col = '0;
      pix_row = (row_cnt_q == 2'd2) ? 2'd2 : row_cnt_q + 2'd1;
    end
    pix_acc   = pix_valid && (pix_col < COL_W'(H_ACTIVE));
    col_cnt_d = pix_acc ? pix_col : col_cnt_q;
    row_cnt_d = pix_acc ? pix_row : row_cnt_q;

    gray_d = pix_acc ? luma    : gray_q;
    col_d  = pix_acc ? pix_col : col_q;
    row_d  = pix_acc ? pix_row : row_q;
    acc_d  = pix_acc;

    // Stage B: shift the window left and insert the column read from the line buffers.
    win_d       = win_q;
    win_valid_d = 1'b0;
    if (acc_q) begin
      win_d       = {win_q[63:48], lb1_rd, win_q[39:24], lb0_rd, win_q[15:0], gray_q};
      win_valid_d = (row_q == 2'd2) && (col_q >= COL_W'(2));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= 2'd0;
      gray_q      <= 8'd0;
      col_q       <= '0;
      row_q       <= 2'd0;
      acc_q       <= 1'b0;
      win_q       <= 72'd0;
      win_valid_q <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      gray_q      <= gray_d;
      col_q       <= col_d;
      row_q       <= row_d;
      acc_q       <= acc_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
    end
  end

  // Line buffers are not reset; reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (acc_q) begin
      lb1[lb_addr] <= lb0_rd;
      lb0[lb_addr] <= gray_q;
    end
  end

  assign win       = win_q;
  assign win_valid = win_valid_q;
  assign gray_out  = gray_q;

endmodule

`default_nettype wire

// File: tb/tb_sobel_window3x3.sv
// tb_sobel_window3x3: randomized frames checked against an image-array reference model.
`default_nettype none

module tb_sobel_window3x3;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic        sol = 1'b0;
  logic [23:0] rgb_in = 24'd0;
  logic        win_valid;
  logic [71:0] win;
  logic [7:0]  gray_out;

  sobel_window3x3 #(.H_ACTIVE(H), .COL_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .sof       (sof),
    .sol       (sol),
    .rgb_in    (rgb_in),
    .win_valid (win_valid),
    .win       (win),
    .gray_out  (gray_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: luma image of the current frame plus expectations one stage behind.
  logic [7:0]  img [0:15][0:7];
  logic [7:0]  m_gray = 8'd0;
  logic        e_v1 = 1'b0;
  logic [71:0] e_w1 = 72'd0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] luma_ref(input logic [23:0] c);
`ifdef SOBEL_WIN_LUMA_EN
    int s;
    s = int'(c[23:16]) + 2 * int'(c[15:8]) + int'(c[7:0]);
    return 8'(s / 4);
`else
    return c[15:8];
`endif
  endfunction

  function automatic logic [71:0] window_ref(input int y, input int x);
    return {img[y-2][x-2], img[y-2][x-1], img[y-2][x],
            img[y-1][x-2], img[y-1][x-1], img[y-1][x],
            img[y][x-2],   img[y][x-1],   img[y][x]};
  endfunction

  // One clock: present inputs, step the model, compare after the edge.
  task automatic drive(input logic pv, input logic f, input logic l, input logic [23:0] rgb,
                       input int y, input int idx);
    logic acc;
    pix_valid = pv; sof = f; sol = l; rgb_in = rgb;
    @(posedge clk); #1;
    acc = pv && (idx < H);
    if (acc) begin
      img[y][idx] = luma_ref(rgb);
      m_gray      = luma_ref(rgb);
    end
    chk("gray_out", 72'(gray_out), 72'(m_gray));
    chk("win_valid", 72'(win_valid), 72'(e_v1));
    if (e_v1) chk("win", win, e_w1);
    e_v1 = acc && (y >= 2) && (idx >= 2);
    if (e_v1) e_w1 = window_ref(y, idx);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
  endtask

  task automatic run_frame(input int nlines, input bit ramp, input bit gaps, input bit ovf,
                           input int ab_line, input int ab_col);
    int len;
    logic [7:0] v;
    logic [23:0] c;
    for (int yy = 0; yy < nlines; yy++) begin
      len = ovf ? H + int'($urandom_range(0, 2)) : H;
      for (int idx = 0; idx < len; idx++) begin
        if (yy == ab_line && idx == ab_col) return;
        if (gaps && $urandom_range(0, 3) == 0) begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle();
        end
        v = 8'(yy * 16 + idx);
        c = ramp ? {v, v, v} : 24'($urandom);
        drive(1'b1, (yy == 0 && idx == 0), (idx == 0), c, yy, idx);
        if (ramp && yy == 2 && idx == 3) begin
          chk("ramp_p22_valid", 72'(win_valid), 72'd1);
          chk("ramp_p22_win", win, 72'h000102101112202122);
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_win_valid"}, 72'(win_valid), 72'd0);
    chk({tag, "_win"}, win, 72'd0);
    chk({tag, "_gray"}, 72'(gray_out), 72'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_init");
    reset = 1'b0;
    @(posedge clk); #1;
    check_zero("rst_idle");

    // Directed luma values, each on a fresh sof pixel.
`ifdef SOBEL_WIN_LUMA_EN
    drive(1'b1, 1'b1, 1'b1, 24'hFFFFFF, 0, 0); chk("luma_ffffff", 72'(gray_out), 72'hFF);
    drive(1'b1, 1'b1, 1'b1, 24'h102030, 0, 0); chk("luma_102030", 72'(gray_out), 72'h20);
    drive(1'b1, 1'b1, 1'b1, 24'hFF0000, 0, 0); chk("luma_ff0000", 72'(gray_out), 72'h3F);
`else
    drive(1'b1, 1'b1, 1'b1, 24'h102030, 0, 0); chk("luma_102030", 72'(gray_out), 72'h20);
    drive(1'b1, 1'b1, 1'b1, 24'hFF00FF, 0, 0); chk("luma_ff00ff", 72'(gray_out), 72'h00);
`endif
    idle(); idle();

    run_frame(5, 1'b1, 1'b0, 1'b0, -1, -1);
    idle(); idle();

    for (int f = 0; f < 3; f++) run_frame(6, 1'b0, 1'b1, 1'b1, -1, -1);

    // Abort at row 3 col 4: that pixel becomes sof of a new frame.
    run_frame(5, 1'b0, 1'b0, 1'b0, 3, 4);
    run_frame(5, 1'b0, 1'b1, 1'b0, -1, -1);
    idle(); idle();

    // Asynchronous reset in the middle of a line.
    run_frame(3, 1'b0, 1'b0, 1'b0, -1, -1);
    drive(1'b1, 1'b0, 1'b1, 24'($urandom), 3, 0);
    drive(1'b1, 1'b0, 1'b0, 24'($urandom), 3, 1);
    drive(1'b1, 1'b0, 1'b0, 24'($urandom), 3, 2);
    pix_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero("rst_async");
    @(posedge clk); #1;
    check_zero("rst_held");
    reset = 1'b0;
    m_gray = 8'd0;
    e_v1   = 1'b0;
    @(posedge clk); #1;
    check_zero("rst_rel1");
    @(posedge clk); #1;
    check_zero("rst_rel2");

    run_frame(4, 1'b0, 1'b1, 1'b1, -1, -1);
    idle(); idle(); idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
